// File: rtl/sstim_gen.sv
// Pseudo-random signed stimulus source: Galois LFSR operand stream with data-valid,
// a delayed expect-valid for the monitor, a sample counter and a sticky done flag.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | out of reset, waiting for the first en
// S_RUN   | emitting one sample per cycle while en is high
// S_DRAIN | all samples emitted, waiting for the exp_valid pipe to empty
// S_DONE  | finished, done held until reset
module sstim_gen #(
    parameter int          DATAWIDTH   = 32,
    parameter logic [31:0] SEED        = 32'h00000001,
    parameter int          NUM_SAMPLES = 1000,
    parameter int          DELAY       = 1,
    localparam int         CW          = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        en,
    output logic signed [DATAWIDTH-1:0] data,
    output logic                        data_valid,
    output logic                        exp_valid,
    output logic [CW-1:0]               count,
    output logic                        done
);

    localparam logic [31:0]   MASK     = 32'h80200003;
    localparam logic [31:0]   SEED_EFF = (SEED == 32'h0) ? 32'h00000001 : SEED;
    localparam logic [CW-1:0] LAST     = CW'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] lfsr;
    logic [3:0]  drain_cnt;
    logic        emit;
    logic        last_emit;
    logic        drain_tc;

    // state register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (last_emit) state_next = S_DRAIN;
                     else if (emit) state_next = S_RUN;
            S_RUN:   if (last_emit) state_next = S_DRAIN;
            S_DRAIN: if (drain_tc)  state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // output decode
    always_comb begin
        emit      = 1'b0;
        done      = 1'b0;
        last_emit = 1'b0;
        drain_tc  = (drain_cnt == 4'd0);
        case (state)
            S_IDLE, S_RUN: begin
                emit      = en;
                last_emit = en && (count == LAST);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // sample datapath; drain timer counts DELAY cycles after the last emit
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            lfsr       <= SEED_EFF;
            data       <= '0;
            data_valid <= 1'b0;
            count      <= '0;
            drain_cnt  <= 4'd0;
        end else begin
            data_valid <= emit;
            if (emit) begin
                data  <= $signed(lfsr[DATAWIDTH-1:0]);
                lfsr  <= lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
                count <= count + CW'(1);
            end
            if (last_emit)
                drain_cnt <= 4'(DELAY);
            else if (state == S_DRAIN && !drain_tc)
                drain_cnt <= drain_cnt - 4'd1;
        end
    end

    // exp_valid pipe is fed regardless of state so pauses keep their shape
    generate
        if (DELAY == 0) begin : g_nodly
            assign exp_valid = data_valid;
        end else if (DELAY == 1) begin : g_dly1
            logic dly;
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) dly <= 1'b0;
                else      dly <= data_valid;
            end
            assign exp_valid = dly;
        end else begin : g_dlyn
            logic [DELAY-1:0] dly;
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) dly <= '0;
                else      dly <= {dly[DELAY-2:0], data_valid};
            end
            assign exp_valid = dly[DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_sstim_gen.sv
// Bench for sstim_gen: four instances (widths, delays, sample counts) against a
// behavioural LFSR model with a per-instance scoreboard of expected samples.
module tb_sstim_gen;

    localparam int P_DW [4] = '{32, 8, 32, 32};
    localparam int P_N  [4] = '{5, 1000, 1000, 2};
    localparam int P_DL [4] = '{3, 1, 2, 0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en_v [4];

    always #5 clk = ~clk;

    logic signed [31:0] a_data, c_data, d_data;
    logic signed [7:0]  b_data;
    logic [2:0]         a_count;
    logic [9:0]         b_count, c_count;
    logic [1:0]         d_count;
    logic               a_dv, b_dv, c_dv, d_dv;
    logic               a_ev, b_ev, c_ev, d_ev;
    logic               a_done, b_done, c_done, d_done;

    sstim_gen #(.DATAWIDTH(32), .SEED(32'h1), .NUM_SAMPLES(5), .DELAY(3)) u_a (
        .Clk(clk), .Rst(rst), .en(en_v[0]), .data(a_data), .data_valid(a_dv),
        .exp_valid(a_ev), .count(a_count), .done(a_done));
    sstim_gen #(.DATAWIDTH(8), .SEED(32'h1), .NUM_SAMPLES(1000), .DELAY(1)) u_b (
        .Clk(clk), .Rst(rst), .en(en_v[1]), .data(b_data), .data_valid(b_dv),
        .exp_valid(b_ev), .count(b_count), .done(b_done));
    sstim_gen #(.DATAWIDTH(32), .SEED(32'h1), .NUM_SAMPLES(1000), .DELAY(2)) u_c (
        .Clk(clk), .Rst(rst), .en(en_v[2]), .data(c_data), .data_valid(c_dv),
        .exp_valid(c_ev), .count(c_count), .done(c_done));
    sstim_gen #(.DATAWIDTH(32), .SEED(32'h0), .NUM_SAMPLES(2), .DELAY(0)) u_d (
        .Clk(clk), .Rst(rst), .en(en_v[3]), .data(d_data), .data_valid(d_dv),
        .exp_valid(d_ev), .count(d_count), .done(d_done));

    logic [31:0] o_data [4];
    logic [31:0] o_cnt  [4];
    logic        o_dv   [4];
    logic        o_ev   [4];
    logic        o_done [4];

    assign o_data[0] = a_data;
    assign o_data[1] = {24'h0, b_data};
    assign o_data[2] = c_data;
    assign o_data[3] = d_data;
    assign o_cnt[0]  = {29'h0, a_count};
    assign o_cnt[1]  = {22'h0, b_count};
    assign o_cnt[2]  = {22'h0, c_count};
    assign o_cnt[3]  = {30'h0, d_count};
    assign o_dv   = '{a_dv, b_dv, c_dv, d_dv};
    assign o_ev   = '{a_ev, b_ev, c_ev, d_ev};
    assign o_done = '{a_done, b_done, c_done, d_done};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // behavioural model
    logic [31:0] m_lfsr [4];
    logic [31:0] m_data [4];
    logic [31:0] m_cnt  [4];
    logic [31:0] m_hist [4];
    logic        m_dv   [4];
    int          m_since [4];
    logic [31:0] sbq [4][$];
    logic [31:0] known [4];

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    function automatic logic [31:0] dw_mask(input int dw);
        return (dw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << dw) - 32'h1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lfsr[i]  = 32'h1;
            m_data[i]  = '0;
            m_cnt[i]   = '0;
            m_hist[i]  = '0;
            m_dv[i]    = 1'b0;
            m_since[i] = -1;
            sbq[i].delete();
        end
    endtask

    // advance the model across one rising edge using the en values just driven
    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            logic emit;
            emit = en_v[i] && (m_cnt[i] < 32'(P_N[i]));
            m_hist[i] = {m_hist[i][30:0], m_dv[i]};
            m_dv[i] = emit;
            if (m_since[i] >= 0) m_since[i]++;
            if (emit) begin
                m_data[i] = m_lfsr[i] & dw_mask(P_DW[i]);
                sbq[i].push_back(m_data[i]);
                m_lfsr[i] = lfsr_next(m_lfsr[i]);
                m_cnt[i]++;
                if (m_cnt[i] == 32'(P_N[i])) m_since[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            logic exp_ev;
            logic [31:0] sb_exp;
            exp_ev = (P_DL[i] == 0) ? m_dv[i] : m_hist[i][P_DL[i]-1];
            chk($sformatf("dv%0d", i),    32'(o_dv[i]),   32'(m_dv[i]));
            chk($sformatf("ev%0d", i),    32'(o_ev[i]),   32'(exp_ev));
            chk($sformatf("data%0d", i),  o_data[i],      m_data[i]);
            chk($sformatf("count%0d", i), o_cnt[i],       m_cnt[i]);
            chk($sformatf("done%0d", i),  32'(o_done[i]), 32'(m_since[i] >= P_DL[i] + 1));
            if (o_dv[i]) begin
                sb_exp = (sbq[i].size() != 0) ? sbq[i].pop_front() : ~o_data[i];
                chk($sformatf("sb%0d", i), o_data[i], sb_exp);
                if ((i == 0 || i == 2) && m_cnt[i] >= 1 && m_cnt[i] <= 4)
                    chk($sformatf("seq%0d", i), o_data[i], known[m_cnt[i]-1]);
                if (i == 1 && m_cnt[i] == 2)
                    chk("signed8", 32'(int'(b_data)), 32'd3);
            end
        end
    endtask

    initial begin
        known = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001};
        for (int i = 0; i < 4; i++) en_v[i] = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            en_v[0] = (cyc < 10) ? 1'b1 : 1'($urandom_range(0, 1));
            en_v[1] = (cyc < 6) || (cyc >= 21);
            en_v[2] = (cyc == 0) || (cyc == 3) || (cyc == 4) || (cyc >= 21);
            en_v[3] = (cyc < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rst) model_step();
            @(negedge clk);
            check_all();
            if (cyc == 19) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_all();
            end else if (cyc == 20) begin
                rst = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("sb_left%0d", i), 32'(sbq[i].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
